// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU/RV32M op codes, branch codes,
// the controller state code for EX and the local FSM encoding.
package exec_pkg;

    localparam logic [2:0] STATE_EX = 3'd2;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
        ALU_LUI, ALU_AUIPC, ALU_MUL, ALU_MULH, ALU_MULHSU,
        ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [3:0] {
        BR_NONE, BR_BEQ, BR_BNE, BR_BLT, BR_BGE,
        BR_BLTU, BR_BGEU, BR_JAL, BR_JALR
    } br_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULW   = 2'd1,
        S_DIVRUN = 2'd2,
        S_DONE   = 2'd3
    } ex_fsm_e;

    function automatic logic is_mul_op(input alu_op_e op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic is_div_op(input alu_op_e op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/exec_stage_div_unit.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// sign fix-up and divide-by-zero handling applied on the final iteration.
module div_unit
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            done
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] rem_q, quo_q, divisor_q, dividend_q;
    logic [CW-1:0]   count;
    logic            busy, neg_q, neg_r, div_zero;

    logic [XLEN:0]   rem_shift, diff;
    logic            fits;
    logic [XLEN-1:0] rem_next, quo_next;
    logic            a_neg, b_neg;

    assign a_neg     = is_signed & dividend[XLEN-1];
    assign b_neg     = is_signed & divisor[XLEN-1];
    assign rem_shift = {rem_q, quo_q[XLEN-1]};
    assign diff      = rem_shift - {1'b0, divisor_q};
    assign fits      = ~diff[XLEN];
    assign rem_next  = fits ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    assign quo_next  = {quo_q[XLEN-2:0], fits};

    // Results are combinational on the last iteration so the owner can latch them on that edge.
    assign done      = busy && (count == CW'(XLEN - 1));
    assign quotient  = div_zero ? '1 : (neg_q ? -quo_next : quo_next);
    assign remainder = div_zero ? dividend_q : (neg_r ? -rem_next : rem_next);

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            count      <= '0;
            busy       <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
        end else if (start) begin
            rem_q      <= '0;
            quo_q      <= a_neg ? -dividend : dividend;
            divisor_q  <= b_neg ? -divisor : divisor;
            dividend_q <= dividend;
            count      <= '0;
            busy       <= 1'b1;
            neg_q      <= a_neg ^ b_neg;
            neg_r      <= a_neg;
            div_zero   <= (divisor == '0);
        end else if (busy) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            count <= count + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ALU, branch resolution, 2-cycle multiplier and iterative
// divider; registers all memory-stage inputs and raises ex_done when valid.
module exec_stage
    import exec_pkg::*;
#(
    parameter int         XLEN     = 32,
    parameter logic [2:0] EX_STATE = STATE_EX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      state,
    input  logic [4:0]      alu_op,
    input  logic [3:0]      branch_op,
    input  logic            use_imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            reg_write_in,
    input  logic [4:0]      write_reg_in,
    output logic            ex_done,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_write_data,
    output logic            branch,
    output logic            reg_write,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] branch_addr,
    output logic [XLEN-1:0] reg_write_data,
    output logic [1:0]      fsm_state
);
    alu_op_e op;
    br_op_e  br;
    ex_fsm_e fsm;

    logic [XLEN-1:0]   op_b, sum_addr, pc_imm, link, alu_result, br_target, result_data;
    logic              in_ex, is_mul, is_div, br_taken, is_link;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic              mul_hi;
    logic [XLEN-1:0]   div_q, div_r;
    logic              div_done, div_start, div_abort, div_signed;
    logic              alu_fire, mul_fire, div_fire, latch_now;

    assign op        = alu_op_e'(alu_op);
    assign br        = br_op_e'(branch_op);
    assign fsm_state = fsm;
    assign in_ex     = (state == EX_STATE);
    assign is_mul    = is_mul_op(op);
    assign is_div    = is_div_op(op);
    assign op_b      = use_imm ? imm : rs2_data;
    assign sum_addr  = rs1_data + imm;
    assign pc_imm    = pc + imm;
    assign link      = pc + XLEN'(4);
    assign is_link   = (br == BR_JAL) || (br == BR_JALR);

    always_comb begin
        alu_result = '0;
        case (op)
            ALU_ADD:   alu_result = rs1_data + op_b;
            ALU_SUB:   alu_result = rs1_data - op_b;
            ALU_SLL:   alu_result = rs1_data << op_b[4:0];
            ALU_SLT:   alu_result = XLEN'($signed(rs1_data) < $signed(op_b));
            ALU_SLTU:  alu_result = XLEN'(rs1_data < op_b);
            ALU_XOR:   alu_result = rs1_data ^ op_b;
            ALU_SRL:   alu_result = rs1_data >> op_b[4:0];
            ALU_SRA:   alu_result = $unsigned($signed(rs1_data) >>> op_b[4:0]);
            ALU_OR:    alu_result = rs1_data | op_b;
            ALU_AND:   alu_result = rs1_data & op_b;
            ALU_LUI:   alu_result = op_b;
            ALU_AUIPC: alu_result = pc_imm;
            default:   alu_result = '0;
        endcase
    end

    always_comb begin
        br_taken  = 1'b0;
        br_target = pc_imm;
        case (br)
            BR_BEQ:  br_taken = (rs1_data == rs2_data);
            BR_BNE:  br_taken = (rs1_data != rs2_data);
            BR_BLT:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
            BR_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
            BR_BLTU: br_taken = (rs1_data < rs2_data);
            BR_BGEU: br_taken = (rs1_data >= rs2_data);
            BR_JAL:  br_taken = 1'b1;
            BR_JALR: begin
                br_taken  = 1'b1;
                br_target = {sum_addr[XLEN-1:1], 1'b0};
            end
            default: br_target = '0;
        endcase
    end

    // Low 2*XLEN bits of the product of sign/zero-extended operands cover all MUL variants.
    assign mul_a = {{XLEN{(op != ALU_MULHU) & rs1_data[XLEN-1]}}, rs1_data};
    assign mul_b = {{XLEN{(op == ALU_MUL || op == ALU_MULH) & op_b[XLEN-1]}}, op_b};

    assign div_signed = (op == ALU_DIV) || (op == ALU_REM);
    assign div_start  = (fsm == S_IDLE) && in_ex && is_div;
    assign div_abort  = (fsm == S_DIVRUN) && !in_ex;

    div_unit #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (div_abort),
        .is_signed (div_signed),
        .dividend  (rs1_data),
        .divisor   (op_b),
        .quotient  (div_q),
        .remainder (div_r),
        .done      (div_done)
    );

    assign alu_fire  = (fsm == S_IDLE) && in_ex && !is_mul && !is_div;
    assign mul_fire  = (fsm == S_MULW) && in_ex;
    assign div_fire  = (fsm == S_DIVRUN) && in_ex && div_done;
    assign latch_now = alu_fire || mul_fire || div_fire;

    always_comb begin
        result_data = is_link ? link : alu_result;
        if (fsm == S_MULW)
            result_data = mul_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        else if (fsm == S_DIVRUN)
            result_data = (op == ALU_REM || op == ALU_REMU) ? div_r : div_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm            <= S_IDLE;
            prod           <= '0;
            mul_hi         <= 1'b0;
            ex_done        <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            branch         <= 1'b0;
            reg_write      <= 1'b0;
            write_reg      <= '0;
            branch_addr    <= '0;
            reg_write_data <= '0;
        end else begin
            if (latch_now) begin
                ex_done        <= 1'b1;
                mem_read       <= mem_read_in;
                mem_write      <= mem_write_in;
                mem_addr       <= sum_addr;
                mem_write_data <= rs2_data;
                branch         <= br_taken;
                reg_write      <= reg_write_in;
                write_reg      <= write_reg_in;
                branch_addr    <= br_target;
                reg_write_data <= result_data;
            end
            case (fsm)
                S_IDLE: begin
                    if (in_ex) begin
                        if (is_mul) begin
                            prod   <= mul_a * mul_b;
                            mul_hi <= (op != ALU_MUL);
                            fsm    <= S_MULW;
                        end else if (is_div) begin
                            fsm <= S_DIVRUN;
                        end else begin
                            fsm <= S_DONE;
                        end
                    end
                end
                S_MULW:   fsm <= in_ex ? S_DONE : S_IDLE;
                S_DIVRUN: begin
                    if (!in_ex)        fsm <= S_IDLE;
                    else if (div_done) fsm <= S_DONE;
                end
                S_DONE: begin
                    if (!in_ex) begin
                        fsm     <= S_IDLE;
                        ex_done <= 1'b0;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: hand-computed vectors for ALU, branches,
// multiplier, divider, reset abort and controller-state abort.
module tb_exec_stage;
    import exec_pkg::*;

    logic        clk, rst;
    logic [2:0]  state;
    logic [4:0]  alu_op;
    logic [3:0]  branch_op;
    logic        use_imm;
    logic [31:0] rs1_data, rs2_data, imm, pc;
    logic        mem_read_in, mem_write_in, reg_write_in;
    logic [4:0]  write_reg_in;
    logic        ex_done, mem_read, mem_write, branch, reg_write;
    logic [31:0] mem_addr, mem_write_data, branch_addr, reg_write_data;
    logic [4:0]  write_reg;
    logic [1:0]  fsm_state;

    int n_vec = 0;
    int n_err = 0;

    exec_stage dut (
        .clk(clk), .rst(rst), .state(state), .alu_op(alu_op), .branch_op(branch_op),
        .use_imm(use_imm), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
        .write_reg_in(write_reg_in), .ex_done(ex_done), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .branch(branch), .reg_write(reg_write), .write_reg(write_reg),
        .branch_addr(branch_addr), .reg_write_data(reg_write_data), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_op(input logic [4:0] op, input logic [3:0] br, input logic ui,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] i, input logic [31:0] p);
        alu_op = op; branch_op = br; use_imm = ui;
        rs1_data = a; rs2_data = b; imm = i; pc = p;
        state = 3'd2;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!ex_done && edges < 100);
    endtask

    task automatic leave_ex;
        state = 3'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_op(ALU_ADD, BR_JAL, 1'b1, 32'd7, 32'd9, 32'd3, 32'h40);
        mem_read_in = 1'b1; mem_write_in = 1'b1; reg_write_in = 1'b1; write_reg_in = 5'd3;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (ex_done !== 1'b0) begin n_err++; $display("FAIL reset_ex_done: got %b want 0", ex_done); end
        n_vec++; if (reg_write_data !== 32'h0) begin n_err++; $display("FAIL reset_rwd: got %h want 0", reg_write_data); end
        n_vec++; if ({branch, mem_read, mem_write, reg_write} !== 4'b0) begin n_err++; $display("FAIL reset_ctl: got %b want 0000", {branch, mem_read, mem_write, reg_write}); end
        n_vec++; if (mem_addr !== 32'h0 || branch_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h/%h want 0/0", mem_addr, branch_addr); end
        n_vec++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL reset_fsm: got %0d want 0", fsm_state); end
        state = 3'd0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        int edges;
        set_op(ALU_ADD, BR_NONE, 1'b1, 32'd5, 32'h0000DEAD, 32'hFFFFFFFD, 32'h0);
        mem_read_in = 1'b1; mem_write_in = 1'b0; reg_write_in = 1'b1; write_reg_in = 5'd9;
        wait_done(edges);
        n_vec++; if (edges !== 1) begin n_err++; $display("FAIL add_latency: got %0d want 1", edges); end
        n_vec++; if (reg_write_data !== 32'd2) begin n_err++; $display("FAIL add_data: got %h want 2", reg_write_data); end
        n_vec++; if (mem_addr !== 32'd2 || mem_write_data !== 32'h0000DEAD) begin n_err++; $display("FAIL add_mem: got %h/%h want 2/dead", mem_addr, mem_write_data); end
        n_vec++; if ({mem_read, mem_write, reg_write, write_reg} !== {3'b101, 5'd9}) begin n_err++; $display("FAIL add_ctl: got %b want 10101001", {mem_read, mem_write, reg_write, write_reg}); end
        n_vec++; if (branch !== 1'b0 || branch_addr !== 32'h0) begin n_err++; $display("FAIL add_br: got %b/%h want 0/0", branch, branch_addr); end
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (ex_done !== 1'b1) begin n_err++; $display("FAIL done_hold: got %b want 1", ex_done); end
        leave_ex;
        n_vec++; if (ex_done !== 1'b0) begin n_err++; $display("FAIL done_drop: got %b want 0", ex_done); end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic        ui;
        logic [31:0] a, b, i, p, exp;
    } alu_vec_t;

    task automatic test_alu_ops;
        alu_vec_t v[9];
        int edges;
        v[0] = '{ALU_SUB,   1'b0, 32'd3,        32'd5,        32'd0,        32'h0,   32'hFFFFFFFE};
        v[1] = '{ALU_SLT,   1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,   32'd1};
        v[2] = '{ALU_SLTU,  1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,   32'd0};
        v[3] = '{ALU_SRA,   1'b1, 32'h80000000, 32'd0,        32'd4,        32'h0,   32'hF8000000};
        v[4] = '{ALU_SRL,   1'b1, 32'h80000000, 32'd0,        32'd4,        32'h0,   32'h08000000};
        v[5] = '{ALU_SLL,   1'b1, 32'd1,        32'd0,        32'd33,       32'h0,   32'd2};
        v[6] = '{ALU_LUI,   1'b1, 32'd0,        32'd0,        32'h12345000, 32'h0,   32'h12345000};
        v[7] = '{ALU_AUIPC, 1'b1, 32'd0,        32'd0,        32'h2000,     32'h100, 32'h2100};
        v[8] = '{ALU_XOR,   1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'h0,   32'h0FF00FF0};
        for (int k = 0; k < 9; k++) begin
            set_op(v[k].op, BR_NONE, v[k].ui, v[k].a, v[k].b, v[k].i, v[k].p);
            wait_done(edges);
            n_vec++; if (reg_write_data !== v[k].exp || edges !== 1) begin n_err++; $display("FAIL alu_op%0d: got %h in %0d edges want %h in 1", v[k].op, reg_write_data, edges, v[k].exp); end
            leave_ex;
        end
    endtask

    task automatic test_branch;
        int edges;
        set_op(ALU_ADD, BR_BLT, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100);
        wait_done(edges);
        n_vec++; if (branch !== 1'b1 || branch_addr !== 32'h120) begin n_err++; $display("FAIL blt: got %b/%h want 1/120", branch, branch_addr); end
        leave_ex;
        set_op(ALU_ADD, BR_BLTU, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h20, 32'h100);
        wait_done(edges);
        n_vec++; if (branch !== 1'b0 || branch_addr !== 32'h120) begin n_err++; $display("FAIL bltu: got %b/%h want 0/120", branch, branch_addr); end
        leave_ex;
        set_op(ALU_ADD, BR_JALR, 1'b1, 32'h1003, 32'd0, 32'd0, 32'h40);
        wait_done(edges);
        n_vec++; if (branch !== 1'b1 || branch_addr !== 32'h1002 || reg_write_data !== 32'h44) begin n_err++; $display("FAIL jalr: got %b/%h/%h want 1/1002/44", branch, branch_addr, reg_write_data); end
        leave_ex;
        set_op(ALU_ADD, BR_JAL, 1'b1, 32'h777, 32'd0, 32'h10, 32'h40);
        wait_done(edges);
        n_vec++; if (branch !== 1'b1 || branch_addr !== 32'h50 || reg_write_data !== 32'h44) begin n_err++; $display("FAIL jal: got %b/%h/%h want 1/50/44", branch, branch_addr, reg_write_data); end
        leave_ex;
        set_op(ALU_ADD, BR_BEQ, 1'b0, 32'd8, 32'd8, 32'hFFFFFFF0, 32'h8);
        wait_done(edges);
        n_vec++; if (branch !== 1'b1 || branch_addr !== 32'hFFFFFFF8) begin n_err++; $display("FAIL beq: got %b/%h want 1/fffffff8", branch, branch_addr); end
        leave_ex;
    endtask

    task automatic test_mul;
        int edges;
        set_op(ALU_MULH, BR_NONE, 1'b0, 32'h80000000, 32'h80000000, 32'd0, 32'h0);
        wait_done(edges);
        n_vec++; if (edges !== 2 || reg_write_data !== 32'h40000000) begin n_err++; $display("FAIL mulh: got %h in %0d edges want 40000000 in 2", reg_write_data, edges); end
        leave_ex;
        set_op(ALU_MULHU, BR_NONE, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h0);
        wait_done(edges);
        n_vec++; if (edges !== 2 || reg_write_data !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mulhu: got %h in %0d edges want fffffffe in 2", reg_write_data, edges); end
        leave_ex;
        set_op(ALU_MUL, BR_NONE, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h0);
        wait_done(edges);
        n_vec++; if (reg_write_data !== 32'h1) begin n_err++; $display("FAIL mul_lo: got %h want 1", reg_write_data); end
        leave_ex;
        set_op(ALU_MULHSU, BR_NONE, 1'b0, 32'hFFFFFFFF, 32'd2, 32'd0, 32'h0);
        wait_done(edges);
        n_vec++; if (reg_write_data !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mulhsu: got %h want ffffffff", reg_write_data); end
        leave_ex;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, exp;
    } div_vec_t;

    task automatic test_div;
        div_vec_t v[8];
        int edges;
        v[0] = '{ALU_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        v[1] = '{ALU_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        v[2] = '{ALU_DIV,  32'd5,        32'd0,        32'hFFFFFFFF};
        v[3] = '{ALU_REMU, 32'd5,        32'd0,        32'd5};
        v[4] = '{ALU_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB};
        v[5] = '{ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        v[6] = '{ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0};
        v[7] = '{ALU_DIVU, 32'd100,      32'd7,        32'd14};
        for (int k = 0; k < 8; k++) begin
            set_op(v[k].op, BR_NONE, 1'b0, v[k].a, v[k].b, 32'd0, 32'h0);
            wait_done(edges);
            n_vec++; if (reg_write_data !== v[k].exp || edges !== 33) begin n_err++; $display("FAIL div%0d: got %h in %0d edges want %h in 33", k, reg_write_data, edges, v[k].exp); end
            leave_ex;
        end
    endtask

    task automatic test_reset_mid_div;
        int edges;
        set_op(ALU_DIV, BR_NONE, 1'b0, 32'd1000, 32'd3, 32'd0, 32'h0);
        repeat (11) @(posedge clk);
        #1;
        n_vec++; if (ex_done !== 1'b0 || fsm_state !== 2'd2) begin n_err++; $display("FAIL div_running: got %b/%0d want 0/2", ex_done, fsm_state); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (ex_done !== 1'b0 || reg_write_data !== 32'h0 || mem_write_data !== 32'h0) begin n_err++; $display("FAIL rst_mid_div: got %b/%h/%h want 0/0/0", ex_done, reg_write_data, mem_write_data); end
        rst = 1'b0;
        set_op(ALU_ADD, BR_NONE, 1'b1, 32'd5, 32'd0, 32'hFFFFFFFD, 32'h0);
        wait_done(edges);
        n_vec++; if (edges !== 1 || reg_write_data !== 32'd2) begin n_err++; $display("FAIL add_after_rst: got %h in %0d edges want 2 in 1", reg_write_data, edges); end
        leave_ex;
    endtask

    task automatic test_state_abort;
        set_op(ALU_MUL, BR_NONE, 1'b0, 32'd3, 32'd4, 32'd0, 32'h0);
        @(posedge clk); #1;
        n_vec++; if (fsm_state !== 2'd1) begin n_err++; $display("FAIL mulw_state: got %0d want 1", fsm_state); end
        state = 3'd3;
        @(posedge clk); #1;
        n_vec++; if (fsm_state !== 2'd0 || ex_done !== 1'b0 || reg_write_data !== 32'd2) begin n_err++; $display("FAIL mul_abort: got %0d/%b/%h want 0/0/2", fsm_state, ex_done, reg_write_data); end
        state = 3'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; state = 3'd0; alu_op = '0; branch_op = '0; use_imm = 1'b0;
        rs1_data = '0; rs2_data = '0; imm = '0; pc = '0;
        mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0; write_reg_in = '0;
        test_reset;
        test_add;
        test_alu_ops;
        test_branch;
        test_mul;
        test_div;
        test_reset_mid_div;
        test_state_abort;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
